pole_parallel_pipe: RTL and testbench

POLE_PARALLEL_PIPE -- requirements
Module: pole_parallel_pipe

---
 rtl/pole_parallel_pipe.sv | 114 +++++++++++
 tb/tb_pole_parallel_pipe.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pole_parallel_pipe.sv
// Pipelined direct-form FIR: delay line, registered products, registered full-width sum,
// then a saturating output register. Double-buffered coefficients allow glitch-free bank swaps.
module pole_parallel_pipe #(
    parameter int DW   = 12,
    parameter int CW   = 12,
    parameter int TAPS = 7,
    parameter int OW   = 26,
    parameter int AW   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    input  logic                 clr,
    input  logic                 coef_we,
    input  logic        [AW-1:0] coef_addr,
    input  logic signed [CW-1:0] coef_wdata,
    input  logic                 coef_swap,
    output logic                 out_valid,
    output logic signed [OW-1:0] out_data,
    output logic                 out_sat
);

    localparam int PW = DW + CW;
    localparam int SW = PW + $clog2(TAPS);
    localparam logic signed [SW-1:0] SAT_MAX = (SW'(1) <<< (OW - 1)) - SW'(1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [CW-1:0] shadow [TAPS];
    logic signed [CW-1:0] active [TAPS];
    logic signed [DW-1:0] tap    [TAPS];
    logic signed [PW-1:0] prod   [TAPS];
    logic signed [SW-1:0] sum;
    logic                 v1, v2, v3;

    logic signed [SW-1:0] sum_next;
    logic signed [OW-1:0] sat_data;
    logic                 sat_flag;

    // NOTE: the banks are plain registers rather than a RAM, so they can be cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            // The swap reads shadow before this edge's write lands, so a colliding write stays shadow-only.
            if (coef_swap) active <= shadow;
            for (int k = 0; k < TAPS; k++) begin
                if (coef_we && coef_addr == AW'(k)) shadow[k] <= coef_wdata;
            end
        end
    end

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        sum_next = '0;
        for (int k = 0; k < TAPS; k++) sum_next = sum_next + SW'(prod[k]);
    end

    always_comb begin
        sat_data = sum[OW-1:0];
        sat_flag = 1'b0;
        if (sum > SAT_MAX) begin
            sat_data = SAT_MAX[OW-1:0];
            sat_flag = 1'b1;
        end else if (sum < SAT_MIN) begin
            sat_data = SAT_MIN[OW-1:0];
            sat_flag = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int k = 0; k < TAPS; k++) begin
                tap[k]  <= '0;
                prod[k] <= '0;
            end
            sum       <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
            if (rst) begin
                out_data <= '0;
                out_sat  <= 1'b0;
            end
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                tap[0] <= in_data;
                for (int k = 1; k < TAPS; k++) tap[k] <= tap[k-1];
            end

            v2 <= v1;
            if (v1) begin
                for (int k = 0; k < TAPS; k++) prod[k] <= PW'(tap[k]) * PW'(active[k]);
            end

            v3 <= v2;
            if (v2) sum <= sum_next;

            // Output register holds its last value between valid pulses.
            out_valid <= v3;
            if (v3) begin
                out_data <= sat_data;
                out_sat  <= sat_flag;
            end
        end
    end

endmodule

// File: tb/tb_pole_parallel_pipe.sv
// Self-checking bench: two DUT widths (OW=26 and OW=24) share stimulus and are compared
// every cycle against a sample-history model, plus directed scenarios with literal expectations.
module tb_pole_parallel_pipe;

    localparam int DW = 12, CW = 12, TAPS = 7, AW = 4;
    localparam int OWA = 26, OWB = 24;

    logic                  clk = 1'b0;
    logic                  rst, in_valid, clr, coef_we, coef_swap;
    logic signed [DW-1:0]  in_data;
    logic        [AW-1:0]  coef_addr;
    logic signed [CW-1:0]  coef_wdata;
    logic                  out_valid_a, out_sat_a, out_valid_b, out_sat_b;
    logic signed [OWA-1:0] out_data_a;
    logic signed [OWB-1:0] out_data_b;

    always #5 clk = ~clk;

    pole_parallel_pipe #(.DW(DW), .CW(CW), .TAPS(TAPS), .OW(OWA), .AW(AW)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr(clr),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_swap(coef_swap),
        .out_valid(out_valid_a), .out_data(out_data_a), .out_sat(out_sat_a)
    );

    pole_parallel_pipe #(.DW(DW), .CW(CW), .TAPS(TAPS), .OW(OWB), .AW(AW)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr(clr),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_swap(coef_swap),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_sat(out_sat_b)
    );

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat_val(input longint v, input int ow);
        longint mx;
        mx = (longint'(1) <<< (ow - 1)) - 1;
        if (v > mx) return mx;
        if (v < -mx - 1) return -mx - 1;
        return v;
    endfunction

    function automatic longint sat_flag(input longint v, input int ow);
        return (sat_val(v, ow) != v) ? 1 : 0;
    endfunction

    // Model: the output for a sample is the dot product of the last TAPS accepted samples
    // (since the last flush) with the active bank in force when the sample was accepted,
    // appearing three edges after acceptance.
    int     shadow_m [TAPS];
    int     active_m [TAPS];
    longint hist     [TAPS];
    bit     pend_v   [1:3];
    longint pend_d   [1:3];
    bit     m_valid = 1'b0;
    longint m_sum   = 0;

    always @(posedge clk) begin
        int     a;
        longint s;
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                shadow_m[k] = 0;
                active_m[k] = 0;
                hist[k]     = 0;
            end
            for (int j = 1; j <= 3; j++) pend_v[j] = 1'b0;
            m_valid = 1'b0;
            m_sum   = 0;
        end else begin
            if (coef_swap) active_m = shadow_m;
            a = int'(coef_addr);
            if (coef_we && a < TAPS) shadow_m[a] = int'(coef_wdata);
            if (clr) begin
                for (int k = 0; k < TAPS; k++) hist[k] = 0;
                for (int j = 1; j <= 3; j++) pend_v[j] = 1'b0;
                m_valid = 1'b0;
            end else begin
                m_valid = pend_v[3];
                if (pend_v[3]) m_sum = pend_d[3];
                pend_v[3] = pend_v[2]; pend_d[3] = pend_d[2];
                pend_v[2] = pend_v[1]; pend_d[2] = pend_d[1];
                pend_v[1] = 1'b0;
                if (in_valid) begin
                    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
                    hist[0] = longint'(in_data);
                    s = 0;
                    for (int k = 0; k < TAPS; k++) s += hist[k] * longint'(active_m[k]);
                    pend_v[1] = 1'b1;
                    pend_d[1] = s;
                end
            end
        end
    end

    longint obs_a [$];
    longint obs_b [$];
    longint obs_bs[$];

    always @(negedge clk) begin
        if (checking) begin
            check("valid_a", longint'(out_valid_a), longint'(m_valid));
            check("valid_b", longint'(out_valid_b), longint'(m_valid));
            check("data_a", longint'(out_data_a), sat_val(m_sum, OWA));
            check("data_b", longint'(out_data_b), sat_val(m_sum, OWB));
            check("sat_a", longint'(out_sat_a), sat_flag(m_sum, OWA));
            check("sat_b", longint'(out_sat_b), sat_flag(m_sum, OWB));
            if (out_valid_a) obs_a.push_back(longint'(out_data_a));
            if (out_valid_b) begin
                obs_b.push_back(longint'(out_data_b));
                obs_bs.push_back(longint'(out_sat_b));
            end
        end
    end

    task automatic idle_inputs();
        rst = 1'b0; in_valid = 1'b0; clr = 1'b0; coef_we = 1'b0; coef_swap = 1'b0;
        in_data = '0; coef_addr = '0; coef_wdata = '0;
    endtask

    task automatic cyc();
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic push(input int x);
        in_valid = 1'b1;
        in_data  = DW'(x);
        cyc();
    endtask

    task automatic flush();
        clr = 1'b1;
        cyc();
    endtask

    task automatic write_coef(input int addr, input int val);
        coef_we    = 1'b1;
        coef_addr  = AW'(addr);
        coef_wdata = CW'(val);
        cyc();
    endtask

    task automatic load_bank(input int c [TAPS]);
        for (int k = 0; k < TAPS; k++) write_coef(k, c[k]);
        coef_swap = 1'b1;
        cyc();
    endtask

    task automatic expect_seq(input string name, input int base, input longint exp [TAPS]);
        check({name, "_count"}, longint'(obs_a.size() - base), longint'(TAPS));
        for (int i = 0; i < TAPS; i++) begin
            if (base + i < obs_a.size())
                check($sformatf("%s[%0d]", name, i), obs_a[base + i], exp[i]);
        end
    endtask

    initial begin
        int     imp   [TAPS];
        int     cfill [TAPS];
        longint imp_exp [TAPS];
        int     base;

        imp     = '{272, 609, 250, 189, 49, 13, 1};
        imp_exp = '{27200, 60900, 25000, 18900, 4900, 1300, 100};

        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        idle_inputs();
        checking = 1'b1;
        check("reset_valid", longint'(out_valid_a), 0);
        check("reset_data", longint'(out_data_a), 0);

        // Impulse response
        base = obs_a.size();
        load_bank(imp);
        push(100);
        for (int i = 0; i < TAPS - 1; i++) push(0);
        idle(5);
        expect_seq("impulse", base, imp_exp);

        // Saturation at OW=24; same sums fit unclamped at OW=26
        flush();
        for (int k = 0; k < TAPS; k++) cfill[k] = -2048;
        load_bank(cfill);
        base = obs_b.size();
        for (int i = 0; i < TAPS; i++) push(-2048);
        idle(5);
        check("sat_count", longint'(obs_b.size() - base), longint'(TAPS));
        if (obs_b.size() >= base + TAPS) begin
            check("sat_first_data", obs_b[base], 4194304);
            check("sat_first_flag", obs_bs[base], 0);
            check("sat_last_data", obs_b[base + TAPS - 1], 8388607);
            check("sat_last_flag", obs_bs[base + TAPS - 1], 1);
            check("wide_last_data", obs_a[obs_a.size() - 1], 29360128);
        end

        // Gapped impulse
        flush();
        load_bank(imp);
        base = obs_a.size();
        for (int i = 0; i < TAPS; i++) begin
            push(i == 0 ? 100 : 0);
            cyc();
        end
        idle(5);
        expect_seq("gapped", base, imp_exp);

        // Swap mid-stream, then write+swap collision
        flush();
        for (int k = 0; k < TAPS; k++) cfill[k] = 1;
        load_bank(cfill);
        for (int k = 0; k < TAPS; k++) write_coef(k, 2);
        base = obs_a.size();
        for (int i = 0; i < 12; i++) begin
            if (i == 9) coef_swap = 1'b1;
            push(1);
        end
        idle(5);
        check("swap_count", longint'(obs_a.size() - base), 12);
        if (obs_a.size() >= base + 12) begin
            check("swap_before", obs_a[base + 8], 7);
            check("swap_at", obs_a[base + 9], 14);
            check("swap_after", obs_a[base + 11], 14);
        end
        coef_we = 1'b1; coef_addr = AW'(0); coef_wdata = CW'(5); coef_swap = 1'b1;
        cyc();
        push(1);
        idle(5);
        check("collide_old_shadow", obs_a[obs_a.size() - 1], 14);
        coef_swap = 1'b1;
        cyc();
        push(1);
        idle(5);
        check("collide_new_bank", obs_a[obs_a.size() - 1], 17);
        write_coef(9, 77);  // out-of-range address: ignored
        coef_swap = 1'b1;
        cyc();
        push(1);
        idle(5);
        check("addr_ignored", obs_a[obs_a.size() - 1], 17);

        // Clear discards in-flight impulse
        flush();
        load_bank(imp);
        base = obs_a.size();
        push(100);
        flush();
        idle(5);
        check("clr_no_output", longint'(obs_a.size() - base), 0);
        push(3);
        idle(5);
        check("clr_next_count", longint'(obs_a.size() - base), 1);
        check("clr_next_data", obs_a[obs_a.size() - 1], 816);

        // Reset mid-stream
        for (int i = 0; i < TAPS; i++) push(50 + i);
        rst = 1'b1; in_valid = 1'b1; in_data = DW'(9);
        cyc();
        check("rst_valid", longint'(out_valid_a), 0);
        check("rst_data", longint'(out_data_a), 0);
        base = obs_a.size();
        idle(2);
        check("rst_discard", longint'(obs_a.size() - base), 0);
        push(100);
        idle(5);
        check("rst_count", longint'(obs_a.size() - base), 1);
        check("rst_zero_coef", obs_a[obs_a.size() - 1], 0);

        // Randomized traffic against the model
        load_bank(imp);
        for (int i = 0; i < 1500; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_data    = DW'($urandom);
            if ($urandom_range(0, 3) == 0) in_data = ($urandom_range(0, 1) == 1) ? DW'(-2048) : DW'(2047);
            coef_we    = ($urandom_range(0, 5) == 0);
            coef_addr  = AW'($urandom);
            coef_wdata = CW'($urandom);
            if ($urandom_range(0, 3) == 0) coef_wdata = CW'(-2048);
            coef_swap  = ($urandom_range(0, 15) == 0);
            clr        = ($urandom_range(0, 79) == 0);
            rst        = ($urandom_range(0, 399) == 0);
            cyc();
        end
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
